// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the load sequencer and its watchdog timer.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } ld_seq_state_t;

    // Size 3 has no legal encoding, so it is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_bad;
        w_bad = 1'b1;
        if ({1'b0, size} == BYTE)
            w_bad = 1'b0;
        else if ({1'b0, size} == HALF)
            w_bad = addr_lo[0];
        else if ({1'b0, size} == WORD)
            w_bad = (addr_lo != 2'b00);
        return w_bad;
    endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Watchdog counter of consecutive HREADY-low cycles; only built with AHB_LOAD_SEQ_TIMEOUT_EN.
module ahb_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    // Fires on the LIMIT-th low cycle so the sequencer leaves on that edge.
    assign o_expired = i_inc && (r_count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clr || o_expired)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/ahb_load_sequencer.sv
// Single-outstanding AHB-Lite read master driving the HRDATA pipeline register clear/load.
// Optional HREADY watchdog enabled by defining AHB_LOAD_SEQ_TIMEOUT_EN.
module ahb_load_sequencer
    import ahb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              flush,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              pr_clr,
    output logic              rd_valid,
    output logic              ld_err,
    output logic              stall
);

    ld_seq_state_t     r_state;
    ld_seq_state_t     w_next;
    htrans_t           r_htrans;
    logic [ADDR_W-1:0] r_haddr;
    logic [2:0]        r_hsize;
    logic              r_rd_valid;
    logic              r_ld_err;
    logic              r_kill;

    logic w_busy;
    logic w_accept;
    logic w_misaligned;
    logic w_kill;
    logic w_load_done;
    logic w_err_done;
    logic w_timeout;

    assign w_busy       = (r_state != ST_IDLE);
    assign ld_ready     = (r_state == ST_IDLE) && !flush && !rst;
    assign w_accept     = ld_valid && ld_ready;
    assign w_misaligned = is_misaligned(ld_size, ld_addr[1:0]);
    // A flush seen in the completion cycle itself also kills the load.
    assign w_kill       = r_kill || flush;
    assign w_load_done  = (r_state == ST_DATA) && HREADY && !HRESP;
    assign w_err_done   = ((r_state == ST_ERR) && HREADY) ||
                          ((r_state == ST_DATA) && HREADY && HRESP);

    assign pr_clr   = !(w_load_done && !w_kill);
    assign stall    = w_busy;
    assign HADDR    = r_haddr;
    assign HTRANS   = r_htrans;
    assign HSIZE    = r_hsize;
    assign HWRITE   = 1'b0;
    assign rd_valid = r_rd_valid;
    assign ld_err   = r_ld_err;

`ifdef AHB_LOAD_SEQ_TIMEOUT_EN
    logic w_timer_inc;
    logic w_timer_clr;

    assign w_timer_inc = w_busy && !HREADY;
    assign w_timer_clr = !w_busy || HREADY;

    ahb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_timer_clr),
        .i_inc    (w_timer_inc),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: next state gets its default before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_misaligned) w_next = ST_ADDR;
            ST_ADDR: if (HREADY) w_next = ST_DATA;
            ST_DATA: begin
                if (HREADY)
                    w_next = ST_IDLE;
                else if (HRESP)
                    w_next = ST_ERR;
            end
            ST_ERR:  if (HREADY) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_timeout)
            w_next = ST_IDLE;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_htrans   <= IDLE;
            r_haddr    <= '0;
            r_hsize    <= BYTE;
            r_rd_valid <= 1'b0;
            r_ld_err   <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_rd_valid <= w_load_done && !w_kill;
            r_ld_err   <= (w_accept && w_misaligned) ||
                          ((w_err_done || w_timeout) && !w_kill);
            r_kill     <= (w_next != ST_IDLE) && w_kill;
            if (w_accept && !w_misaligned) begin
                r_haddr  <= ld_addr;
                r_hsize  <= {1'b0, ld_size};
                r_htrans <= NONSEQ;
            end else if (((r_state == ST_ADDR) && HREADY) || w_timeout) begin
                r_htrans <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ahb_load_sequencer.sv
// Self-checking bench: transaction-level model of load outcomes and timing, randomized loads.
module tb_ahb_load_sequencer;
    import ahb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              flush;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic              HREADY;
    logic              HRESP;
    logic              pr_clr;
    logic              rd_valid;
    logic              ld_err;
    logic              stall;

    logic [31:0] hrdata;
    logic [31:0] q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The HRDATA pipeline register this block controls.
    always_ff @(posedge clk) begin
        if (pr_clr)
            q <= '0;
        else
            q <= hrdata;
    end

    ahb_load_sequencer #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr (ld_addr),
        .ld_size (ld_size),
        .flush   (flush),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HSIZE   (HSIZE),
        .HWRITE  (HWRITE),
        .HREADY  (HREADY),
        .HRESP   (HRESP),
        .pr_clr  (pr_clr),
        .rd_valid(rd_valid),
        .ld_err  (ld_err),
        .stall   (stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] addr, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return addr[0] == 1'b0;
            2'd2:    return addr[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // One load: aw address-phase waits, dw data-phase waits, optional two-cycle error
    // response, optional flush pulse in cycle flush_cyc (cycle 0 = accept cycle).
    task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input int aw,
                            input int dw, input bit err, input int flush_cyc,
                            input logic [31:0] data);
        bit          legal;
        bit          killed;
        bit          exp_ok;
        bit          exp_err;
        int          cc;
        int          last;
        int          d;
        int          n_clr = 0, clr_at = -1;
        int          n_rd = 0, rd_at = -1;
        int          n_err = 0, err_at = -1;
        int          n_ns = 0, ns_first = -1;
        int          stall_bad = 0;
        logic        rdy_after = 1'b0;
        logic [31:0] q_at_rd = '0;
        logic [31:0] haddr_seen = '0;
        logic [2:0]  hsize_seen = '0;

        legal   = model_legal(addr, size);
        cc      = !legal ? 0 : (err ? 3 + aw + dw : 2 + aw + dw);
        last    = cc + 2;
        killed  = legal && (flush_cyc >= 1) && (flush_cyc <= cc);
        exp_ok  = legal && !err && !killed;
        exp_err = !legal || (err && !killed);

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            ld_valid = (c == 0);
            if (c == 0) begin
                ld_addr = addr;
                ld_size = size;
                hrdata  = data;
            end
            flush  = (c == flush_cyc);
            HREADY = 1'b1;
            HRESP  = 1'b0;
            if (legal && c >= 1 && c <= 1 + aw)
                HREADY = (c == 1 + aw);
            if (legal && c >= 2 + aw) begin
                d = c - (2 + aw);
                if (d < dw) begin
                    HREADY = 1'b0;
                end else if (err && d == dw) begin
                    HREADY = 1'b0;
                    HRESP  = 1'b1;
                end else if (err && d == dw + 1) begin
                    HRESP = 1'b1;
                end
            end
            #1;
            if (c == 0)
                check("accept_ready", ld_ready, 1'b1);
            if (c == 1) begin
                haddr_seen = HADDR;
                hsize_seen = HSIZE;
            end
            if (c == cc + 1)
                rdy_after = ld_ready;
            if (!pr_clr) begin
                n_clr++;
                clr_at = c;
            end
            if (rd_valid) begin
                n_rd++;
                rd_at   = c;
                q_at_rd = q;
            end
            if (ld_err) begin
                n_err++;
                err_at = c;
            end
            if (HTRANS == NONSEQ) begin
                if (n_ns == 0)
                    ns_first = c;
                n_ns++;
            end
            if (stall != (legal && c >= 1 && c <= cc))
                stall_bad++;
        end
        ld_valid = 1'b0;
        flush    = 1'b0;

        check("pr_clr_low_count", n_clr, exp_ok);
        check("rd_valid_count", n_rd, exp_ok);
        check("ld_err_count", n_err, exp_err);
        check("stall_profile_errors", stall_bad, 0);
        check("nonseq_cycles", n_ns, legal ? aw + 1 : 0);
        check("ready_after_done", rdy_after, 1'b1);
        if (exp_ok) begin
            check("pr_clr_low_cycle", clr_at, cc);
            check("rd_valid_cycle", rd_at, cc + 1);
            check("q_data", q_at_rd, data);
        end
        if (exp_err)
            check("ld_err_cycle", err_at, legal ? cc + 1 : 1);
        if (legal) begin
            check("nonseq_first_cycle", ns_first, 1);
            check("haddr", haddr_seen, addr);
            check("hsize", {29'd0, hsize_seen}, {30'd0, size});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        int          aw, dw, fc;
        bit          e;

        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_1000;
        ld_size  = 2'd2;
        flush    = 1'b0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        hrdata   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_htrans", HTRANS, IDLE);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hsize", HSIZE, 3'b000);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_pr_clr", pr_clr, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_ld_err", ld_err, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);

        run_load(32'h0000_1000, 2'd2, 0, 0, 1'b0, -1, 32'hDEAD_BEEF);
        run_load(32'h0000_1000, 2'd2, 0, 3, 1'b0, -1, 32'hDEAD_BEEF);
        run_load(32'h0000_1000, 2'd2, 0, 0, 1'b1, -1, 32'h1234_5678);
        run_load(32'h0000_1001, 2'd1, 0, 0, 1'b0, -1, 32'h0);
        run_load(32'h0000_2000, 2'd2, 0, 3, 1'b0, 3, 32'hCAFE_F00D);
        run_load(32'h0000_2004, 2'd2, 1, 0, 1'b0, -1, 32'h0BAD_F00D);

        // Flush in IDLE only blocks acceptance.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3000;
        ld_size  = 2'd2;
        flush    = 1'b1;
        #1;
        check("flush_idle_ready", ld_ready, 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_idle_stall", stall, 1'b0);
        check("flush_idle_htrans", HTRANS, IDLE);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            s  = 2'($urandom_range(0, 3));
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            e  = ($urandom_range(0, 3) == 0);
            fc = -1;
            if (model_legal(a, s) && $urandom_range(0, 3) == 0)
                fc = $urandom_range(1, 2 + aw + dw);
            run_load(a, s, aw, dw, e, fc, $urandom);
        end

        // Asynchronous reset while a transfer sits in its address phase.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_4000;
        ld_size  = 2'd2;
        @(negedge clk);
        ld_valid = 1'b0;
        HREADY   = 1'b0;
        #1;
        check("midrst_pre_stall", stall, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_htrans", HTRANS, IDLE);
        check("midrst_haddr", HADDR, 32'h0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_pr_clr", pr_clr, 1'b1);
        check("midrst_ld_ready", ld_ready, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        HREADY = 1'b1;

        // Slave holds HREADY low indefinitely after the address phase starts.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_5000;
        ld_size  = 2'd2;
        #1;
        check("hang_accept", ld_ready, 1'b1);
`ifdef AHB_LOAD_SEQ_TIMEOUT_EN
        for (int c = 1; c <= TMO + 1; c++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            HREADY   = 1'b0;
            #1;
            if (c == TMO)
                check("tmo_still_busy", stall, 1'b1);
        end
        check("tmo_htrans", HTRANS, IDLE);
        check("tmo_stall", stall, 1'b0);
        check("tmo_ld_err", ld_err, 1'b1);
        check("tmo_pr_clr", pr_clr, 1'b1);
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            HREADY   = 1'b0;
        end
        #1;
        check("hang_stall", stall, 1'b1);
        check("hang_htrans", HTRANS, NONSEQ);
        check("hang_ld_err", ld_err, 1'b0);
`endif
        @(negedge clk);
        rst    = 1'b1;
        HREADY = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
